// File: rtl/wb_info_stage_if.sv
// rtl/wb_info_stage_if.sv - write-info pipeline register bus: stage inputs, registered outputs, forwarding queries
interface wb_info_stage_if #(
  parameter int LANES   = 2,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int SW      = 3,
  parameter int QUERIES = 2
);
  localparam int NSRC = 2**SW;

  logic                      En;
  logic                      Flush;
  logic [LANES*DW-1:0]       wd_in;
  logic [LANES*AW-1:0]       addr_in;
  logic [LANES*TW-1:0]       tnew_in;
  logic [LANES-1:0]          we_in;
  logic [LANES*SW-1:0]       src_in;
  logic [LANES*NSRC*DW-1:0]  src_data;
  logic [LANES*DW-1:0]       wd;
  logic [LANES*AW-1:0]       addr;
  logic [LANES*TW-1:0]       tnew;
  logic [LANES-1:0]          we;
  logic [LANES*SW-1:0]       src;
  logic [QUERIES*AW-1:0]     q_addr;
  logic [QUERIES-1:0]        q_hit;
  logic [QUERIES*DW-1:0]     q_data;
  logic [QUERIES-1:0]        q_pend;

  modport master (
    output En, Flush, wd_in, addr_in, tnew_in, we_in, src_in, src_data, q_addr,
    input  wd, addr, tnew, we, src, q_hit, q_data, q_pend
  );

  modport slave (
    input  En, Flush, wd_in, addr_in, tnew_in, we_in, src_in, src_data, q_addr,
    output wd, addr, tnew, we, src, q_hit, q_data, q_pend
  );
endinterface

// File: rtl/wb_info_stage.sv
// rtl/wb_info_stage.sv - multi-lane write-info pipeline register with result resolution and forwarding query
module wb_info_stage #(
  parameter int LANES    = 2,
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int SW       = 3,
  parameter int LINK_SRC = 3,
  parameter int LINK_OFS = 4,
  parameter int QUERIES  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  wb_info_stage_if.slave    bus
);
  localparam int NSRC = 2**SW;

  logic [LANES*DW-1:0]   r_wd;
  logic [LANES*AW-1:0]   r_addr;
  logic [LANES*TW-1:0]   r_tnew;
  logic [LANES-1:0]      r_we;
  logic [LANES*SW-1:0]   r_src;

  logic [LANES*DW-1:0]   w_wd_nxt;
  logic [LANES*TW-1:0]   w_tnew_nxt;
  logic [LANES-1:0]      w_we_nxt;

  logic [QUERIES-1:0]    w_q_hit;
  logic [QUERIES-1:0]    w_q_pend;
  logic [QUERIES*DW-1:0] w_q_data;

  // A lane whose result becomes ready here (tnew_in==1) picks its data from the selected source.
  always_comb begin
    w_wd_nxt   = bus.wd_in;
    w_tnew_nxt = '0;
    w_we_nxt   = '0;
    for (int k = 0; k < LANES; k++) begin
      w_we_nxt[k] = bus.we_in[k] & (bus.addr_in[k*AW +: AW] != '0);
      w_tnew_nxt[k*TW +: TW] = (bus.tnew_in[k*TW +: TW] == '0) ? '0
                               : bus.tnew_in[k*TW +: TW] - TW'(1);
      if (bus.we_in[k] && (bus.tnew_in[k*TW +: TW] == TW'(1))
          && (bus.src_in[k*SW +: SW] != '0)) begin
        if (bus.src_in[k*SW +: SW] == SW'(LINK_SRC))
          w_wd_nxt[k*DW +: DW] = bus.src_data[(k*NSRC + LINK_SRC)*DW +: DW] + DW'(LINK_OFS);
        else
          w_wd_nxt[k*DW +: DW] = bus.src_data[(k*NSRC + int'(bus.src_in[k*SW +: SW]))*DW +: DW];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wd   <= '0;
      r_addr <= '0;
      r_tnew <= '0;
      r_we   <= '0;
      r_src  <= '0;
    end else if (bus.Flush) begin
      r_wd   <= '0;
      r_addr <= '0;
      r_tnew <= '0;
      r_we   <= '0;
      r_src  <= '0;
    end else if (bus.En) begin
      r_wd   <= w_wd_nxt;
      r_addr <= bus.addr_in;
      r_tnew <= w_tnew_nxt;
      r_we   <= w_we_nxt;
      r_src  <= bus.src_in;
    end
  end

  // Ascending scan: a later (younger) matching lane overrides any older one, ready or not.
  always_comb begin
    w_q_hit  = '0;
    w_q_pend = '0;
    w_q_data = '0;
    for (int q = 0; q < QUERIES; q++) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_we[k] && (r_addr[k*AW +: AW] == bus.q_addr[q*AW +: AW])
            && (bus.q_addr[q*AW +: AW] != '0)) begin
          w_q_hit[q]           = (r_tnew[k*TW +: TW] == '0);
          w_q_pend[q]          = (r_tnew[k*TW +: TW] != '0);
          w_q_data[q*DW +: DW] = (r_tnew[k*TW +: TW] == '0) ? r_wd[k*DW +: DW] : '0;
        end
      end
    end
  end

  assign bus.wd     = r_wd;
  assign bus.addr   = r_addr;
  assign bus.tnew   = r_tnew;
  assign bus.we     = r_we;
  assign bus.src    = r_src;
  assign bus.q_hit  = w_q_hit;
  assign bus.q_pend = w_q_pend;
  assign bus.q_data = w_q_data;
endmodule

// File: doc/wb_info_stage.md
Name: wb_info_stage

Overview:
- Parametrised multi-lane pipeline register carrying register-file write information (write data, destination, Tnew countdown, write enable, data-source select) between pipeline stages.
- Resolves write data from the stage's candidate sources when an instruction's result becomes ready in this stage.
- Adds stall, flush and r0 suppression, plus a combinational forwarding/hazard query interface for the hazard unit.
- Sits between consecutive stages (E→M, M→W); one instance per boundary.

Parameters:
- LANES, 2, number of parallel issue lanes; lane index order = program order (higher index = younger).
- DW, 32, data width.
- AW, 5, register address width.
- TW, 2, Tnew counter width.
- SW, 3, source-select width; NSRC = 2**SW candidate sources per lane.
- LINK_SRC, 3, source index whose value is written as source+LINK_OFS.
- LINK_OFS, 4, constant added for LINK_SRC.
- QUERIES, 2, number of forwarding query ports.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  advance enable; 0 = hold (stall).
- Flush  in  1  load a bubble into all lanes.
- wd_in  in  LANES*DW  incoming write data, lane k at [k*DW +: DW].
- addr_in  in  LANES*AW  destination register.
- tnew_in  in  LANES*TW  cycles until result ready, at input.
- we_in  in  LANES  register write enable.
- src_in  in  LANES*SW  write-data source select.
- src_data  in  LANES*NSRC*DW  candidate sources; lane k, source s at [(k*NSRC+s)*DW +: DW].
- wd  out  LANES*DW  registered write data.
- addr  out  LANES*AW  registered destination.
- tnew  out  LANES*TW  registered Tnew.
- we  out  LANES  registered write enable.
- src  out  LANES*SW  registered source select.
- q_addr  in  QUERIES*AW  hazard-unit query addresses.
- q_hit  out  QUERIES  a ready result for q_addr is held here.
- q_data  out  QUERIES*DW  forwarded data when q_hit.
- q_pend  out  QUERIES  a matching write is held here but not ready.

Behaviour:
- Reset (Reset=1, asynchronous): all registered outputs 0 regardless of clock or En; q_hit=q_pend=0, q_data=0.
- Update priority at Clk rising edge: Reset > Flush > En. Flush=1 loads 0 into every lane field regardless of En. En=0 and Flush=0: all registers hold. Otherwise each lane loads independently as below.
- Write-enable capture: we[k] <= we_in[k] & (addr_in[k] != 0). r0 writes are discarded at capture.
- Address and source capture: addr <= addr_in; src <= src_in, unconditionally.
- Tnew capture: tnew <= (tnew_in==0) ? 0 : tnew_in-1. Saturates at 0 and never wraps.
- Write-data resolution when we_in[k]=1 and tnew_in[k]==1:
  - src_in==0: wd <= wd_in (pass-through).
  - src_in==LINK_SRC: wd <= src_data[k][LINK_SRC] + LINK_OFS, mod 2**DW.
  - Otherwise: wd <= src_data[k][src_in].
- All other cases: wd <= wd_in. Includes tnew_in 0 (already resolved), tnew_in >1 (not yet ready) and we_in=0.
- Latency: one cycle input→output; no combinational input→registered-output path.
- Forwarding query q, combinational from registered state and q_addr:
  - Match lane k when we[k]=1 and addr[k]==q_addr[q] and q_addr[q]!=0.
  - Select the youngest (highest k) matching lane.
  - If the selected lane has tnew==0: q_hit=1, q_pend=0, q_data=wd of that lane.
  - If the selected lane has tnew!=0: q_hit=0, q_pend=1, q_data=0.
  - No match or q_addr==0: q_hit=q_pend=0, q_data=0.
  - An older ready lane is never forwarded when a younger matching lane is pending.
- Stall with Tnew: while En=0, tnew does not count down.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. After deassertion, the first rising edge loads per the priority rules above.

Test Plan:
- Reset mid-operation: load lane0 {addr=5, we=1, tnew_in=2, wd_in=0x11}, assert Reset between edges → all outputs 0 before next edge; q_hit=0 for q_addr=5.
- Resolution: lane0 we=1, tnew_in=1, src=1, src_data[0][1]=0xDEAD_BEEF, wd_in=0x1 → next cycle wd=0xDEADBEEF, tnew=0; q_addr=addr → q_hit=1, q_data=0xDEADBEEF.
- Link offset: src=LINK_SRC, src_data=0xFFFF_FFFE → wd=0x0000_0002 (wraps); separately src=0, tnew_in=1, wd_in=0x55 → wd=0x55.
- Tnew saturation/stall: tnew_in=2 → tnew=1; hold En=0 three cycles → tnew stays 1, wd unchanged; tnew_in=0 → tnew=0.
- Youngest-wins and pending: lane0 {addr=7, ready, wd=0xA}, lane1 {addr=7, tnew=1} → q_hit=0, q_pend=1; make lane1 ready with wd=0xB → q_hit=1, q_data=0xB.
- Flush and r0: Flush=1 with En=0 → all lanes 0 next edge; load we_in=1, addr_in=0 → we=0, q_addr=0 → q_hit=q_pend=0.
